smart_lock: RTL and testbench

SMART_LOCK -- requirements
Module: smart_lock

---
 rtl/smart_lock.sv | 224 ++++++++++++++++++++++
 tb/tb_smart_lock.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/smart_lock.sv
// smart_lock: keypad door lock with a three-slot code table.
// Unlocked, a 4-digit entry can be stored (enter) or removed (delete);
// locked, the 4th accepted digit is checked against the stored codes.
// Optional feature: define SMART_LOCK_LOCKOUT_EN to add a fail counter that
// puts the lock into a 64-cycle LOCKOUT state after 3 failed unlocks.
module smart_lock (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] buttons,
    input  logic       enter,
    input  logic       delete,
    input  logic       lock,
    output logic       error,
    output logic       doorLocked
);

`ifdef SMART_LOCK_LOCKOUT_EN
    typedef enum logic [1:0] {ST_UNLOCKED, ST_LOCKED, ST_LOCKOUT} state_t;
`else
    typedef enum logic [1:0] {ST_UNLOCKED, ST_LOCKED} state_t;
`endif

    // Map a one-hot keypad word to its BCD digit.
    function automatic logic [3:0] f_encode(input logic [9:0] b);
        f_encode = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (b[i]) f_encode = 4'(i);
        end
    endfunction

    state_t            r_state;
    logic [9:0]        r_btn_prev;
    logic              r_enter_prev;
    logic              r_delete_prev;
    logic              r_lock_prev;
    logic [15:0]       r_buf;
    logic [2:0]        r_count;
    logic [2:0][15:0]  r_code;
    logic [2:0]        r_valid;
    logic              r_error;
    logic              r_door;
`ifdef SMART_LOCK_LOCKOUT_EN
    logic [1:0]        r_fail;
    logic [5:0]        r_timer;
    logic [1:0]        w_fail_nxt;
    logic [5:0]        w_timer_nxt;
`endif

    state_t            w_state_nxt;
    logic [15:0]       w_buf_nxt;
    logic [2:0]        w_count_nxt;
    logic [2:0][15:0]  w_code_nxt;
    logic [2:0]        w_valid_nxt;
    logic              w_error_nxt;
    logic              w_door_nxt;

    logic              w_enter_edge;
    logic              w_delete_edge;
    logic              w_lock_edge;
    logic              w_digit_ok;
    logic [3:0]        w_digit;
    logic [15:0]       w_cand;
    logic [2:0]        w_buf_hit;
    logic [2:0]        w_cand_hit;
    logic              w_free_any;
    logic [1:0]        w_free_idx;

    // A digit is only taken from a clean single-key press out of an idle keypad.
    assign w_enter_edge  = enter  & ~r_enter_prev;
    assign w_delete_edge = delete & ~r_delete_prev;
    assign w_lock_edge   = lock   & ~r_lock_prev;
    assign w_digit_ok    = (r_btn_prev == 10'd0) && $onehot(buttons);
    assign w_digit       = f_encode(buttons);
    assign w_cand        = {r_buf[11:0], w_digit};

    // Table lookups: buffer match (enter/delete), candidate match (unlock), lowest free slot.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_buf_hit[i]  = r_valid[i] && (r_code[i] == r_buf);
            w_cand_hit[i] = r_valid[i] && (r_code[i] == w_cand);
        end
        w_free_any = ~&r_valid;
        if (!r_valid[0])      w_free_idx = 2'd0;
        else if (!r_valid[1]) w_free_idx = 2'd1;
        else                  w_free_idx = 2'd2;
    end

    // Next-state and registered-output logic; lock beats enter/delete beats digit.
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_count_nxt = r_count;
        w_code_nxt  = r_code;
        w_valid_nxt = r_valid;
        w_error_nxt = 1'b0;
        w_door_nxt  = r_door;
`ifdef SMART_LOCK_LOCKOUT_EN
        w_fail_nxt  = r_fail;
        w_timer_nxt = r_timer;
`endif
        case (r_state)
            ST_UNLOCKED: begin
                if (w_lock_edge) begin
                    w_state_nxt = ST_LOCKED;
                    w_door_nxt  = 1'b1;
                    w_buf_nxt   = 16'd0;
                    w_count_nxt = 3'd0;
                end else if (w_enter_edge || w_delete_edge) begin
                    w_buf_nxt   = 16'd0;
                    w_count_nxt = 3'd0;
                    if (w_enter_edge && w_delete_edge) begin
                        w_error_nxt = 1'b1;
                    end else if (r_count != 3'd4) begin
                        w_error_nxt = 1'b1;
                    end else if (w_enter_edge) begin
                        if ((|w_buf_hit) || !w_free_any) begin
                            w_error_nxt = 1'b1;
                        end else begin
                            w_code_nxt[w_free_idx]  = r_buf;
                            w_valid_nxt[w_free_idx] = 1'b1;
                        end
                    end else begin
                        if (|w_buf_hit) w_valid_nxt = r_valid & ~w_buf_hit;
                        else            w_error_nxt = 1'b1;
                    end
                end else if (w_digit_ok && (r_count < 3'd4)) begin
                    w_buf_nxt   = w_cand;
                    w_count_nxt = r_count + 3'd1;
                end
            end
            ST_LOCKED: begin
                // enter/delete have no meaning while locked and are dropped.
                if (w_lock_edge) begin
                    w_buf_nxt   = 16'd0;
                    w_count_nxt = 3'd0;
                end else if (w_digit_ok) begin
                    if (r_count == 3'd3) begin
                        w_buf_nxt   = 16'd0;
                        w_count_nxt = 3'd0;
                        if (|w_cand_hit) begin
                            w_state_nxt = ST_UNLOCKED;
                            w_door_nxt  = 1'b0;
`ifdef SMART_LOCK_LOCKOUT_EN
                            w_fail_nxt  = 2'd0;
`endif
                        end else begin
                            w_error_nxt = 1'b1;
`ifdef SMART_LOCK_LOCKOUT_EN
                            if (r_fail == 2'd2) begin
                                w_state_nxt = ST_LOCKOUT;
                                w_fail_nxt  = 2'd0;
                                w_timer_nxt = 6'd63;
                            end else begin
                                w_fail_nxt  = r_fail + 2'd1;
                            end
`endif
                        end
                    end else begin
                        w_buf_nxt   = w_cand;
                        w_count_nxt = r_count + 3'd1;
                    end
                end
            end
`ifdef SMART_LOCK_LOCKOUT_EN
            ST_LOCKOUT: begin
                // Error stays asserted for the whole penalty; all input is dropped.
                if (r_timer == 6'd0) begin
                    w_state_nxt = ST_LOCKED;
                end else begin
                    w_error_nxt = 1'b1;
                    w_timer_nxt = r_timer - 6'd1;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_UNLOCKED;
                w_door_nxt  = 1'b0;
                w_buf_nxt   = 16'd0;
                w_count_nxt = 3'd0;
            end
        endcase
    end

    // State, table, edge-detect samples and outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_UNLOCKED;
            r_btn_prev    <= 10'd0;
            r_enter_prev  <= 1'b0;
            r_delete_prev <= 1'b0;
            r_lock_prev   <= 1'b0;
            r_buf         <= 16'd0;
            r_count       <= 3'd0;
            r_code        <= '0;
            r_valid       <= 3'd0;
            r_error       <= 1'b0;
            r_door        <= 1'b0;
`ifdef SMART_LOCK_LOCKOUT_EN
            r_fail        <= 2'd0;
            r_timer       <= 6'd0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_btn_prev    <= buttons;
            r_enter_prev  <= enter;
            r_delete_prev <= delete;
            r_lock_prev   <= lock;
            r_buf         <= w_buf_nxt;
            r_count       <= w_count_nxt;
            r_code        <= w_code_nxt;
            r_valid       <= w_valid_nxt;
            r_error       <= w_error_nxt;
            r_door        <= w_door_nxt;
`ifdef SMART_LOCK_LOCKOUT_EN
            r_fail        <= w_fail_nxt;
            r_timer       <= w_timer_nxt;
`endif
        end
    end

    assign error      = r_error;
    assign doorLocked = r_door;

endmodule

// File: tb/tb_smart_lock.sv
// Directed bench for smart_lock: storage, deletion, unlock, priority and reset.
module tb_smart_lock;
    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] buttons;
    logic       enter;
    logic       delete;
    logic       lock;
    logic       error;
    logic       doorLocked;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    smart_lock dut (
        .clk(clk), .reset(reset), .buttons(buttons), .enter(enter),
        .delete(delete), .lock(lock), .error(error), .doorLocked(doorLocked)
    );

    // One-cycle stimulus followed by an idle cycle; returns on the negedge
    // right after the edge that acted on it.
    task automatic drive(input logic [9:0] b, input logic en, input logic de, input logic lk);
        @(negedge clk); buttons = b; enter = en; delete = de; lock = lk;
        @(negedge clk); buttons = '0; enter = 0; delete = 0; lock = 0;
    endtask

    task automatic digit(input int d);
        logic [9:0] v;
        v = '0; v[d] = 1'b1;
        drive(v, 0, 0, 0);
    endtask

    task automatic code4(input logic [15:0] c);
        digit(int'(c[15:12])); digit(int'(c[11:8])); digit(int'(c[7:4])); digit(int'(c[3:0]));
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 0;
        @(negedge clk); reset = 1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
        checks++; if (doorLocked !== 1'b0) begin errors++; $display("FAIL reset_door: got %b want 0", doorLocked); end
        @(negedge clk); reset = 1;
    endtask

    task automatic test_store();
        code4(16'h1234); drive('0, 1, 0, 0);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL store_err: got %b want 0", error); end
        checks++; if (doorLocked !== 1'b0) begin errors++; $display("FAIL store_door: got %b want 0", doorLocked); end
        drive('0, 0, 0, 1);
        checks++; if (doorLocked !== 1'b1) begin errors++; $display("FAIL lock_door: got %b want 1", doorLocked); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL lock_err: got %b want 0", error); end
        code4(16'h1234);
        checks++; if (doorLocked !== 1'b0) begin errors++; $display("FAIL store_unlock: got %b want 0", doorLocked); end
    endtask

    task automatic test_table_full();
        do_reset();
        code4(16'h1234); drive('0, 1, 0, 0);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL fill0: got %b want 0", error); end
        code4(16'h5678); drive('0, 1, 0, 0);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL fill1: got %b want 0", error); end
        code4(16'h9012); drive('0, 1, 0, 0);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL fill2: got %b want 0", error); end
        code4(16'h3456); drive('0, 1, 0, 0);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL full_err: got %b want 1", error); end
        @(negedge clk);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b want 0", error); end
        code4(16'h1234); drive('0, 1, 0, 0);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL dup_err: got %b want 1", error); end
    endtask

    task automatic test_delete();
        code4(16'h3456); drive('0, 0, 1, 0);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL del_nomatch: got %b want 1", error); end
        code4(16'h5678); drive('0, 0, 1, 0);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL del_match: got %b want 0", error); end
        code4(16'h3456); drive('0, 1, 0, 0);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL store_after_del: got %b want 0", error); end
        drive('0, 0, 0, 1);
        code4(16'h5678);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL deleted_code_err: got %b want 1", error); end
        checks++; if (doorLocked !== 1'b1) begin errors++; $display("FAIL deleted_code_door: got %b want 1", doorLocked); end
        code4(16'h3456);
        checks++; if (doorLocked !== 1'b0) begin errors++; $display("FAIL new_code_unlock: got %b want 0", doorLocked); end
    endtask

    task automatic test_unlock();
        do_reset();
        code4(16'h1234); drive('0, 1, 0, 0);
        drive('0, 0, 0, 1);
        code4(16'h1357);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL wrong_err: got %b want 1", error); end
        checks++; if (doorLocked !== 1'b1) begin errors++; $display("FAIL wrong_door: got %b want 1", doorLocked); end
        digit(1); digit(2); digit(3);
        checks++; if (doorLocked !== 1'b1) begin errors++; $display("FAIL third_digit_door: got %b want 1", doorLocked); end
        digit(4);
        checks++; if (doorLocked !== 1'b0) begin errors++; $display("FAIL right_door: got %b want 0", doorLocked); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL right_err: got %b want 0", error); end
    endtask

    task automatic test_short_and_reset();
        do_reset();
        digit(1); digit(2); drive('0, 1, 0, 0);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL short_enter: got %b want 1", error); end
        code4(16'h1234); drive('0, 1, 0, 0);
        drive('0, 0, 0, 1);
        digit(1); digit(2);
        #2 reset = 0;
        #1;
        checks++; if (doorLocked !== 1'b0) begin errors++; $display("FAIL async_rst_door: got %b want 0", doorLocked); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL async_rst_err: got %b want 0", error); end
        @(negedge clk); reset = 1;
        drive('0, 0, 0, 1);
        code4(16'h1234);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL empty_table_err: got %b want 1", error); end
        checks++; if (doorLocked !== 1'b1) begin errors++; $display("FAIL empty_table_door: got %b want 1", doorLocked); end
    endtask

    task automatic test_priority();
        logic [9:0] v;
        do_reset();
        code4(16'h1234); drive('0, 1, 0, 0);
        code4(16'h1234); drive('0, 1, 1, 0);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL enter_delete_err: got %b want 1", error); end
        digit(9); digit(0); digit(1);
        v = '0; v[2] = 1'b1; drive(v, 1, 0, 0);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL enter_beats_digit: got %b want 1", error); end
        code4(16'h5678); drive('0, 1, 0, 1);
        checks++; if (doorLocked !== 1'b1) begin errors++; $display("FAIL lock_beats_enter_door: got %b want 1", doorLocked); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL lock_beats_enter_err: got %b want 0", error); end
        drive('0, 1, 0, 0);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL locked_enter_ignored: got %b want 0", error); end
        code4(16'h5678);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL not_stored_5678: got %b want 1", error); end
        digit(1); digit(2); drive('0, 0, 0, 1);
        code4(16'h1234);
        checks++; if (doorLocked !== 1'b0) begin errors++; $display("FAIL lock_clears_buf: got %b want 0", doorLocked); end
        digit(1); digit(2); digit(3);
        v = '0; v[4] = 1'b1; drive(v, 0, 0, 1);
        checks++; if (doorLocked !== 1'b1) begin errors++; $display("FAIL lock_beats_digit: got %b want 1", doorLocked); end
        code4(16'h1234);
        checks++; if (doorLocked !== 1'b0) begin errors++; $display("FAIL unlock_after_prio: got %b want 0", doorLocked); end
    endtask

    task automatic test_digit_filter();
        do_reset();
        code4(16'h4321); digit(9); drive('0, 1, 0, 0);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL fifth_digit_store: got %b want 0", error); end
        code4(16'h4321); drive('0, 1, 0, 0);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL fifth_digit_dup: got %b want 1", error); end
        drive('0, 0, 0, 1);
        digit(4); digit(3); drive(10'b0000000110, 0, 0, 0); digit(2); digit(1);
        checks++; if (doorLocked !== 1'b0) begin errors++; $display("FAIL multibit_ignored: got %b want 0", doorLocked); end
    endtask

`ifdef SMART_LOCK_LOCKOUT_EN
    task automatic test_lockout();
        int hi;
        do_reset();
        code4(16'h1234); drive('0, 1, 0, 0);
        drive('0, 0, 0, 1);
        code4(16'h1111); code4(16'h2222); code4(16'h3333);
        hi = 0;
        for (int k = 0; k < 200; k++) begin
            if (error !== 1'b1) break;
            hi++;
            buttons = '0;
            if (k < 8 && (k % 2) == 0) buttons[k / 2 + 1] = 1'b1;
            @(negedge clk);
        end
        buttons = '0;
        checks++; if (hi != 64) begin errors++; $display("FAIL lockout_len: got %0d want 64", hi); end
        checks++; if (doorLocked !== 1'b1) begin errors++; $display("FAIL lockout_door: got %b want 1", doorLocked); end
        code4(16'h1234);
        checks++; if (doorLocked !== 1'b0) begin errors++; $display("FAIL post_lockout_unlock: got %b want 0", doorLocked); end
    endtask
`else
    task automatic test_lockout();
        do_reset();
        code4(16'h1234); drive('0, 1, 0, 0);
        drive('0, 0, 0, 1);
        code4(16'h1111); code4(16'h2222); code4(16'h3333);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL third_fail_err: got %b want 1", error); end
        @(negedge clk);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL no_lockout_err: got %b want 0", error); end
        code4(16'h1234);
        checks++; if (doorLocked !== 1'b0) begin errors++; $display("FAIL no_lockout_unlock: got %b want 0", doorLocked); end
    endtask
`endif

    initial begin
        reset = 0; buttons = '0; enter = 0; delete = 0; lock = 0;
        test_reset();
        test_store();
        test_table_full();
        test_delete();
        test_unlock();
        test_short_and_reset();
        test_priority();
        test_digit_filter();
        test_lockout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
